ram_sweep_sp: RTL and testbench

Parametrised single-port synchronous RAM, WORDSIZE x 2^ADDR_SIZE, the successor of the fixed 16x8 CPU data RAM. It adds a registered read with a valid strobe and a ready/request handshake. A hardware init sweeper writes INIT_VALUE to every location after reset or on a clear command. It sits between the CPU datapath and its memory address register.

---
 rtl/ram_sweep_sp.sv | 96 +++++++++
 tb/tb_ram_sweep_sp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ram_sweep_sp.sv
// Single-port RAM with registered read, valid strobe, and a hardware init sweep
// that runs after reset or a clear pulse. Optional parity: define RAM_SWEEP_PARITY_EN.
module ram_sweep_sp #(
  parameter int                  WORDSIZE   = 8,
  parameter int                  ADDR_SIZE  = 4,
  parameter logic [WORDSIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 write_en,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORDSIZE-1:0]  data_in,
  input  logic                 clear,
`ifdef RAM_SWEEP_PARITY_EN
  input  logic                 parity_inject,
  output logic                 parity_err,
`endif
  output logic                 ready,
  output logic                 rd_valid,
  output logic [WORDSIZE-1:0]  data_out
);
  localparam int DEPTH = 1 << ADDR_SIZE;
`ifdef RAM_SWEEP_PARITY_EN
  localparam int MW = WORDSIZE + 1;
`else
  localparam int MW = WORDSIZE;
`endif

  typedef enum logic {INIT, IDLE} state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] cnt;
  logic [MW-1:0]        mem [DEPTH];

  logic                 acc, wr_acc, rd_acc, wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [WORDSIZE-1:0]  wr_data;
  logic [MW-1:0]        wr_word;
  logic [MW-1:0]        rd_word;

  // clear wins over req: the cycle clear is seen accepts nothing
  assign ready  = (state == IDLE) && !clear;
  assign acc    = req && ready;
  assign wr_acc = acc && write_en;
  assign rd_acc = acc && !write_en;

  always_comb begin
    wr_en   = (state == INIT) || wr_acc;
    wr_addr = (state == INIT) ? cnt : addr;
    wr_data = (state == INIT) ? INIT_VALUE : data_in;
`ifdef RAM_SWEEP_PARITY_EN
    wr_word = {(^wr_data) ^ (wr_acc & parity_inject), wr_data};
`else
    wr_word = wr_data;
`endif
  end

  assign rd_word = mem[addr];

  // Array has no reset; the sweep is what gives it defined contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
`ifdef RAM_SWEEP_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_acc;
`ifdef RAM_SWEEP_PARITY_EN
      parity_err <= rd_acc ? (^rd_word) : 1'b0;
`endif
      if (rd_acc) data_out <= rd_word[WORDSIZE-1:0];
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= IDLE;
        end
        IDLE: begin
          if (clear) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_sweep_sp.sv
// Directed bench for ram_sweep_sp (8x16, INIT_VALUE=A5): vector table plus
// hand sequences for sweep length, clear collision and mid-sweep reset.
module tb_ram_sweep_sp;
  logic       clk = 1'b0;
  logic       rst_n, req, write_en, clear;
  logic [3:0] addr;
  logic [7:0] data_in, data_out;
  logic       ready, rd_valid;
`ifdef RAM_SWEEP_PARITY_EN
  logic       parity_inject, parity_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_sweep_sp #(.WORDSIZE(8), .ADDR_SIZE(4), .INIT_VALUE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .write_en(write_en), .addr(addr),
    .data_in(data_in), .clear(clear),
`ifdef RAM_SWEEP_PARITY_EN
    .parity_inject(parity_inject), .parity_err(parity_err),
`endif
    .ready(ready), .rd_valid(rd_valid), .data_out(data_out)
  );

  typedef struct {
    logic       req, we;
    logic [3:0] addr;
    logic [7:0] din;
    logic       clr;
    logic       e_rdy, e_vld;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [3:0] a,
                       input logic [7:0] d, input logic c);
    req = r; write_en = we; addr = a; data_in = d; clear = c;
  endtask

  // Counts edges until ready rises; bounded so a stuck sweep still ends the run
  task automatic wait_ready(input string name, input int exp);
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, exp);
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    drive(1'b1, 1'b0, a, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    chk({name, "_vld"}, rd_valid, 1'b1);
    chk({name, "_dout"}, data_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
`ifdef RAM_SWEEP_PARITY_EN
    parity_inject = 1'b0;
`endif
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_vld", rd_valid, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    #22 rst_n = 1'b1;

    wait_ready("sweep_len", 16);
    for (int i = 0; i < 16; i++) rd($sformatf("init_rd%0d", i), 4'(i), 8'hA5);

    //          req   we    addr   din    clr   rdy   vld   dout
    vt[0]  = '{1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[1]  = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C};
    vt[2]  = '{1'b1, 1'b0, 4'd6, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[3]  = '{1'b1, 1'b0, 4'd8, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[4]  = '{1'b0, 1'b0, 4'd7, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[5]  = '{1'b1, 1'b1, 4'd1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[6]  = '{1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[7]  = '{1'b1, 1'b1, 4'd3, 8'h33, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[8]  = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11};
    vt[9]  = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22};
    vt[10] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33};
    vt[11] = '{1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33};
    vt[12] = '{1'b1, 1'b1, 4'd15, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h33};
    vt[13] = '{1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A};
    // clear collides with a write: nothing accepted, sweep restarts
    vt[14] = '{1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h5A};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].din, vt[i].clr);
      #1;
      chk($sformatf("v%0d_ready", i), ready, vt[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), rd_valid, vt[i].e_vld);
      chk($sformatf("v%0d_dout", i), data_out, vt[i].e_dout);
    end
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);

    wait_ready("clear_sweep_len", 16);
    rd("clr_rd2", 4'd2, 8'hA5);
    rd("clr_rd3", 4'd3, 8'hA5);

    // reset at sweep cycle 5 while data_out holds a nonzero value
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_dout", data_out, 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_vld", rd_valid, 1'b0);
    #3 rst_n = 1'b1;
    wait_ready("rst_sweep_len", 16);
    rd("rst_rd7", 4'd7, 8'hA5);

`ifdef RAM_SWEEP_PARITY_EN
    parity_inject = 1'b1;
    drive(1'b1, 1'b1, 4'd4, 8'h01, 1'b0);
    @(posedge clk); #1;
    parity_inject = 1'b0;
    rd("par_bad", 4'd4, 8'h01);
    chk("par_err1", parity_err, 1'b1);
    drive(1'b1, 1'b1, 4'd4, 8'h01, 1'b0);
    @(posedge clk); #1;
    rd("par_good", 4'd4, 8'h01);
    chk("par_err0", parity_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
